// File: rtl/uncached_axi_port.sv
// Uncached sram-like to single-beat AXI bridge, one transaction outstanding at a time.
// Optional feature: define UNCACHED_WBUF_EN for posted stores through a 1-entry write buffer.
module uncached_axi_port #(
  parameter logic [3:0] AXI_ID = 4'd2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        aw_done, w_done;
  logic        done_evt;
  logic        unused_rlast;

  // Every transfer is a single beat, so rlast carries no information.
  assign unused_rlast = rlast;

  assign arid   = AXI_ID;
  assign awid   = AXI_ID;
  assign arlen  = 8'd0;
  assign awlen  = 8'd0;
  assign wlast  = 1'b1;
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;

  always_comb begin
    wstrb = 4'b1111;
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = 4'b0011 << {addr_q[1], 1'b0};
      default: wstrb = 4'b1111;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    data_addr_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (state)
      IDLE: begin
        // The completion cycle is kept free of a new accept.
        data_addr_ok = data_req && !data_data_ok;
        if (data_addr_ok) state_next = data_wr ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_next = IDLE;
      end
      WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_next = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef UNCACHED_WBUF_EN
  assign done_evt = (state == RD_DATA && rvalid) || (data_addr_ok && data_wr);
`else
  assign done_evt = (state == RD_DATA && rvalid) || (state == WR_RESP && bvalid);
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      size_q       <= 2'd0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      data_rdata   <= 32'd0;
      data_data_ok <= 1'b0;
    end else begin
      if (data_addr_ok) begin
        addr_q  <= data_addr;
        size_q  <= data_size;
        wdata_q <= data_wdata;
      end
      // Done flags let AW and W complete independently and in either order.
      if (state == WR_REQ && state_next == WR_REQ) begin
        aw_done <= aw_done || (awvalid && awready);
        w_done  <= w_done || (wvalid && wready);
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == RD_DATA && rvalid) data_rdata <= rdata;
      data_data_ok <= done_evt;
    end
  end

endmodule

// File: tb/tb_uncached_axi_port.sv
// Directed self-checking bench for uncached_axi_port; follows UNCACHED_WBUF_EN when defined.
module tb_uncached_axi_port;

`ifdef UNCACHED_WBUF_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int errors = 0;
  int checks = 0;

  uncached_axi_port dut (
    .aclk(aclk), .aresetn(aresetn),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wd);
    data_req   = req;
    data_wr    = wr;
    data_size  = size;
    data_addr  = addr;
    data_wdata = wd;
  endtask

  initial begin
    aresetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    arready = 0; rvalid = 0; rdata = 0; rlast = 1; awready = 0; wready = 0; bvalid = 0;
    step(); step();
    #1;
    checkOutput("rst_data_ok", {31'd0, data_data_ok}, 32'd0);
    checkOutput("rst_rdata", data_rdata, 32'd0);
    checkOutput("rst_valids", {28'd0, arvalid, awvalid, wvalid, 1'b0}, 32'd0);
    checkOutput("rst_readys", {30'd0, rready, bready}, 32'd0);
    checkOutput("const_ids", {24'd0, arid, awid}, 32'h22);
    checkOutput("const_len_last", {15'd0, arlen, awlen, wlast}, 32'h1);
    aresetn = 1'b1;

    // lw 0x1FAF0000, arready and rvalid at first opportunity
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h1FAF_0000, 32'd0);
    #1 checkOutput("lw_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    step();
    data_req = 1'b0; arready = 1'b1;
    #1 checkOutput("lw_arvalid", {31'd0, arvalid}, 32'd1);
    checkOutput("lw_araddr", araddr, 32'h1FAF_0000);
    checkOutput("lw_arsize", {29'd0, arsize}, 32'd2);
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1 checkOutput("lw_rready", {30'd0, rready, arvalid}, 32'd2);
    checkOutput("lw_no_early_ok", {31'd0, data_data_ok}, 32'd0);
    step();
    rvalid = 1'b0; rdata = 32'd0; data_req = 1'b1;
    #1 checkOutput("lw_data_ok_3cyc", {31'd0, data_data_ok}, 32'd1);
    checkOutput("lw_rdata", data_rdata, 32'hDEAD_BEEF);
    checkOutput("lw_no_accept_on_ok", {31'd0, data_addr_ok}, 32'd0);
    data_req = 1'b0;
    step();
    checkOutput("lw_ok_single", {31'd0, data_data_ok}, 32'd0);

    // sb 0x1FAF0003
    applyStimulus(1'b1, 1'b1, 2'd0, 32'h1FAF_0003, 32'h5A00_0000);
    #1 checkOutput("sb_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    step();
    data_req = 1'b0;
    #1 checkOutput("sb_valids", {30'd0, awvalid, wvalid}, 32'd3);
    checkOutput("sb_awsize", {29'd0, awsize}, 32'd0);
    checkOutput("sb_wstrb", {28'd0, wstrb}, 32'h8);
    checkOutput("sb_wdata", wdata, 32'h5A00_0000);
    checkOutput("sb_awaddr", awaddr, 32'h1FAF_0003);
    checkOutput("sb_posted_ok", {31'd0, data_data_ok}, {31'd0, POSTED});
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    #1 checkOutput("sb_resp_state", {29'd0, awvalid, wvalid, bready}, 32'd1);
    checkOutput("sb_ok_before_b", {31'd0, data_data_ok}, 32'd0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    #1 checkOutput("sb_ok_after_b", {31'd0, data_data_ok}, {31'd0, ~POSTED});
    step();

    // sh 0x1FAF0002, W handshakes three cycles before AW
    applyStimulus(1'b1, 1'b1, 2'd1, 32'h1FAF_0002, 32'h1234_0000);
    step();
    data_req = 1'b0; wready = 1'b1;
    #1 checkOutput("sh_wstrb", {28'd0, wstrb}, 32'hC);
    checkOutput("sh_valids", {30'd0, awvalid, wvalid}, 32'd3);
    step();
    wready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 checkOutput("sh_aw_held", {29'd0, awvalid, wvalid, bready}, 32'd4);
      step();
    end
    awready = 1'b1;
    #1 checkOutput("sh_aw_held_last", {29'd0, awvalid, wvalid, bready}, 32'd4);
    step();
    awready = 1'b0;
    #1 checkOutput("sh_resp", {29'd0, awvalid, wvalid, bready}, 32'd1);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    #1 checkOutput("sh_ok", {31'd0, data_data_ok}, {31'd0, ~POSTED});
    checkOutput("sh_single_b", {31'd0, bready}, 32'd0);
    step();

    // lb with arready held low for five cycles; a new request is ignored meanwhile
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h1FAF_0010, 32'd0);
    step();
    applyStimulus(1'b1, 1'b0, 2'd2, 32'hAAAA_0000, 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1 checkOutput("stall_arvalid", {31'd0, arvalid}, 32'd1);
      checkOutput("stall_araddr", araddr, 32'h1FAF_0010);
      checkOutput("stall_arsize", {29'd0, arsize}, 32'd0);
      checkOutput("stall_addr_ok", {31'd0, data_addr_ok}, 32'd0);
      step();
    end
    data_req = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    #1 checkOutput("stall_rready", {31'd0, rready}, 32'd1);

    // reset while waiting in RD_DATA
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    #1 checkOutput("midrst_valids", {28'd0, arvalid, awvalid, wvalid, rready}, 32'd0);
    checkOutput("midrst_bready_ok", {30'd0, bready, data_data_ok}, 32'd0);
    checkOutput("midrst_rdata", data_rdata, 32'd0);
    data_req = 1'b1;
    #1 checkOutput("midrst_idle", {31'd0, data_addr_ok}, 32'd1);
    data_req = 1'b0;
    step();

`ifdef UNCACHED_WBUF_EN
    // posted sw followed immediately by lw
    applyStimulus(1'b1, 1'b1, 2'd2, 32'h1FAF_0020, 32'h0BAD_F00D);
    step();
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h1FAF_0024, 32'd0);
    #1 checkOutput("wb_sw_ok", {31'd0, data_data_ok}, 32'd1);
    checkOutput("wb_lw_held", {31'd0, data_addr_ok}, 32'd0);
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    #1 checkOutput("wb_lw_held_resp", {30'd0, data_addr_ok, arvalid}, 32'd0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    #1 checkOutput("wb_lw_accept", {30'd0, data_addr_ok, data_data_ok}, 32'd2);
    step();
    data_req = 1'b0;
    #1 checkOutput("wb_ar_after_b", {31'd0, arvalid}, 32'd1);
    checkOutput("wb_araddr", araddr, 32'h1FAF_0024);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
